// File: rtl/button_events.sv
// Button event generator: edge-detects debounced buttons, times long holds for auto-repeat,
// and serialises press/repeat/release events into a small FIFO for the CPU.
module button_events #(
  parameter int unsigned NBTN        = 5,
  parameter int unsigned CW          = 26,
  parameter int unsigned HOLD_CLKS   = 40_000_000,
  parameter int unsigned REPEAT_CLKS = 8_000_000,
  parameter int unsigned LGFIFO      = 3
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [NBTN-1:0] i_btn,
  input  logic            i_rd,
  input  logic            i_ovfl_clr,
  output logic            o_valid,
  output logic [7:0]      o_event,
  output logic            o_overflow,
  output logic            o_int
);

  localparam int unsigned Depth = 2 ** LGFIFO;
  localparam logic [CW-1:0] HoldLoad = CW'(HOLD_CLKS - 1);
  localparam logic [CW-1:0] RepLoad  = CW'(REPEAT_CLKS - 1);
  localparam logic [CW-1:0] CntOne   = CW'(1);
  localparam logic [LGFIFO:0] PtrOne = (LGFIFO + 1)'(1);
  localparam logic [LGFIFO:0] PtrMsb = {1'b1, {LGFIFO{1'b0}}};

  typedef enum logic {StIdle, StHeld} state_e;

  state_e          state_q [NBTN];
  state_e          state_d [NBTN];
  logic [CW-1:0]   cnt_q   [NBTN];
  logic [CW-1:0]   cnt_d   [NBTN];

  logic [NBTN-1:0] prev_q;
  logic [NBTN-1:0] rise, fall;
  logic [NBTN-1:0] set_p, set_r, set_l, fall_clr_r;
  logic [NBTN-1:0] pend_p_q, pend_p_d, pend_r_q, pend_r_d, pend_l_q, pend_l_d;
  logic [NBTN-1:0] sel_oh, sched_clr_p, sched_clr_r, sched_clr_l;
  logic            sel_any, sel_p, sel_r;
  logic [4:0]      sel_idx;
  logic [1:0]      push_type;
  logic [7:0]      push_data;
  logic            push, pop, full, empty, lost;
  logic            ovfl_q, ovfl_d;

  logic [LGFIFO:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]      mem_q [Depth];

  assign rise = i_btn & ~prev_q;
  assign fall = ~i_btn & prev_q;

  // Per-button FSM: state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-button FSM: next state and hold counter
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StIdle: begin
          if (rise[i]) begin
            state_d[i] = StHeld;
            cnt_d[i]   = HoldLoad;
          end
        end
        StHeld: begin
          if (fall[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            cnt_d[i] = RepLoad;
          end else begin
            cnt_d[i] = cnt_q[i] - CntOne;
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // Per-button FSM: event requests; release beats a coincident repeat
  always_comb begin
    set_p      = '0;
    set_r      = '0;
    set_l      = '0;
    fall_clr_r = '0;
    for (int i = 0; i < NBTN; i++) begin
      set_p[i]      = (state_q[i] == StIdle) && rise[i];
      set_l[i]      = (state_q[i] == StHeld) && fall[i];
      set_r[i]      = (state_q[i] == StHeld) && !fall[i] && (cnt_q[i] == '0);
      fall_clr_r[i] = set_l[i];
    end
  end

  // Scheduler: lowest-index button wins, loop runs downward so the last hit is the lowest
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    sel_oh  = '0;
    sel_p   = 1'b0;
    sel_r   = 1'b0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (pend_p_q[i] || pend_r_q[i] || pend_l_q[i]) begin
        sel_any    = 1'b1;
        sel_idx    = 5'(i);
        sel_oh     = '0;
        sel_oh[i]  = 1'b1;
        sel_p      = pend_p_q[i];
        sel_r      = pend_r_q[i];
      end
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = ((wptr_q ^ rptr_q) == PtrMsb);
  assign push  = sel_any && !full;
  assign pop   = i_rd && !empty;

  always_comb begin
    sched_clr_p = '0;
    sched_clr_r = '0;
    sched_clr_l = '0;
    if (sel_p) begin
      push_type = 2'b01;
      if (push) sched_clr_p = sel_oh;
    end else if (sel_r) begin
      push_type = 2'b11;
      if (push) sched_clr_r = sel_oh;
    end else begin
      push_type = 2'b10;
      if (push) sched_clr_l = sel_oh;
    end
  end

  assign push_data = {push_type, 1'b0, sel_idx};

  // New requests in the same cycle survive the scheduler's clear
  assign pend_p_d = (pend_p_q & ~sched_clr_p) | set_p;
  assign pend_r_d = (pend_r_q & ~sched_clr_r & ~fall_clr_r) | set_r;
  assign pend_l_d = (pend_l_q & ~sched_clr_l) | set_l;

  assign lost   = |(set_p & pend_p_q) || |(set_l & pend_l_q);
  assign ovfl_d = lost ? 1'b1 : (i_ovfl_clr ? 1'b0 : ovfl_q);

  assign wptr_d = push ? wptr_q + PtrOne : wptr_q;
  assign rptr_d = pop ? rptr_q + PtrOne : rptr_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_q   <= '0;
      pend_p_q <= '0;
      pend_r_q <= '0;
      pend_l_q <= '0;
      ovfl_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      prev_q   <= i_btn;
      pend_p_q <= pend_p_d;
      pend_r_q <= pend_r_d;
      pend_l_q <= pend_l_d;
      ovfl_q   <= ovfl_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q[LGFIFO-1:0]] <= push_data;
  end

  assign o_valid    = !empty;
  assign o_event    = empty ? 8'h00 : mem_q[rptr_q[LGFIFO-1:0]];
  assign o_overflow = ovfl_q;
  assign o_int      = !empty;

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events: directed scenarios plus random button activity,
// compared every cycle against a hold-time based behavioural model.
module tb_button_events;

  localparam int NB    = 5;
  localparam int HOLD  = 10;
  localparam int REP   = 4;
  localparam int DEPTH = 4;

  logic          i_clk      = 1'b0;
  logic          i_reset_n  = 1'b0;
  logic [NB-1:0] i_btn      = '0;
  logic          i_rd       = 1'b0;
  logic          i_ovfl_clr = 1'b0;
  logic          o_valid;
  logic [7:0]    o_event;
  logic          o_overflow;
  logic          o_int;

  button_events #(
    .NBTN       (NB),
    .CW         (8),
    .HOLD_CLKS  (HOLD),
    .REPEAT_CLKS(REP),
    .LGFIFO     (2)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_btn     (i_btn),
    .i_rd      (i_rd),
    .i_ovfl_clr(i_ovfl_clr),
    .o_valid   (o_valid),
    .o_event   (o_event),
    .o_overflow(o_overflow),
    .o_int     (o_int)
  );

  always #5 i_clk = ~i_clk;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Reference model: button hold age, pending flags per type, event queue
  bit         m_prev [NB];
  bit         m_held [NB];
  int         m_age  [NB];
  bit         m_p    [NB];
  bit         m_r    [NB];
  bit         m_l    [NB];
  logic [7:0] m_q    [$];
  bit         m_ovf;

  logic [7:0] got [$];
  logic [7:0] hold_exp [6] = '{8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h80};

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", phase, tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_prev[i] = 0; m_held[i] = 0; m_age[i] = 0;
      m_p[i] = 0; m_r[i] = 0; m_l[i] = 0;
    end
    m_q.delete();
    m_ovf = 0;
  endtask

  task automatic model_step();
    bit np [NB];
    bit nr [NB];
    bit nl [NB];
    bit full_at_start;
    bit ovf_set;
    int sel;
    full_at_start = (m_q.size() >= DEPTH);
    ovf_set = 0;
    sel = -1;
    for (int i = 0; i < NB; i++) begin
      np[i] = m_p[i]; nr[i] = m_r[i]; nl[i] = m_l[i];
      if (sel < 0 && (m_p[i] || m_r[i] || m_l[i])) sel = i;
    end
    if (i_rd && m_q.size() > 0) void'(m_q.pop_front());
    if (!full_at_start && sel >= 0) begin
      if (m_p[sel]) begin
        m_q.push_back({2'b01, 1'b0, 5'(sel)}); np[sel] = 0;
      end else if (m_r[sel]) begin
        m_q.push_back({2'b11, 1'b0, 5'(sel)}); nr[sel] = 0;
      end else begin
        m_q.push_back({2'b10, 1'b0, 5'(sel)}); nl[sel] = 0;
      end
    end
    for (int i = 0; i < NB; i++) begin
      bit rise, fall;
      rise = i_btn[i] && !m_prev[i];
      fall = !i_btn[i] && m_prev[i];
      if (!m_held[i] && rise) begin
        if (m_p[i]) ovf_set = 1;
        np[i] = 1; m_held[i] = 1; m_age[i] = 0;
      end else if (m_held[i]) begin
        if (fall) begin
          if (m_l[i]) ovf_set = 1;
          nl[i] = 1; nr[i] = 0; m_held[i] = 0;
        end else begin
          m_age[i]++;
          if (m_age[i] >= HOLD && ((m_age[i] - HOLD) % REP) == 0) nr[i] = 1;
        end
      end
      m_prev[i] = i_btn[i];
      m_p[i] = np[i]; m_r[i] = nr[i]; m_l[i] = nl[i];
    end
    if (ovf_set) m_ovf = 1;
    else if (i_ovfl_clr) m_ovf = 0;
  endtask

  task automatic chk_model();
    logic [7:0] exp_ev;
    exp_ev = (m_q.size() > 0) ? m_q[0] : 8'h00;
    chk("valid", 32'(o_valid), 32'(m_q.size() > 0));
    chk("event", 32'(o_event), 32'(exp_ev));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("int", 32'(o_int), 32'(m_q.size() > 0));
  endtask

  task automatic cycle();
    @(posedge i_clk);
    if (i_reset_n) model_step();
    #1;
    chk_model();
  endtask

  task automatic rd_step();
    if (o_valid) begin
      got.push_back(o_event);
      i_rd = 1'b1;
    end else begin
      i_rd = 1'b0;
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    phase = "reset";
    model_reset();
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_event", 32'(o_event), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    chk("rst_int", 32'(o_int), 0);
    cycle();
    #3 i_reset_n = 1'b1;
    phase = "idle";
    for (int c = 0; c < 20; c++) cycle();

    // Single press and release
    phase = "btn2";
    i_btn = 5'b00100;
    cycle();
    chk("no_event_yet", 32'(o_valid), 0);
    i_btn = 5'b00100;
    cycle();
    chk("press", 32'(o_event), 32'h42);
    i_rd = 1'b1; cycle(); i_rd = 1'b0;
    i_btn = 5'b00000;
    cycle();
    cycle();
    chk("release", 32'(o_event), 32'h82);
    i_rd = 1'b1; cycle(); i_rd = 1'b0;
    chk("empty", 32'(o_valid), 0);

    // Long hold with auto-repeat
    phase = "hold";
    got.delete();
    i_btn = 5'b00001;
    for (int c = 0; c < 25; c++) begin rd_step(); cycle(); end
    i_btn = 5'b00000;
    for (int c = 0; c < 5; c++) begin rd_step(); cycle(); end
    i_rd = 1'b0;
    chk("count", 32'(got.size()), 6);
    for (int i = 0; i < 6; i++) if (i < got.size()) chk("seq", 32'(got[i]), 32'(hold_exp[i]));
    chk("no_ovf", 32'(o_overflow), 0);

    // Simultaneous presses are serialised lowest index first
    phase = "simul";
    i_btn = 5'b01010;
    cycle();
    cycle();
    chk("first", 32'(o_event), 32'h41);
    cycle();
    chk("head_kept", 32'(o_event), 32'h41);
    i_rd = 1'b1; cycle(); i_rd = 1'b0;
    chk("second", 32'(o_event), 32'h43);
    i_btn = 5'b00000;
    for (int c = 0; c < 8; c++) begin i_rd = o_valid; cycle(); end
    i_rd = 1'b0;

    // FIFO full, pending press overflows, then drains in order
    phase = "ovfl";
    i_btn = 5'b11111;
    cycle();
    for (int c = 0; c < 6; c++) cycle();
    chk("full_no_ovf", 32'(o_overflow), 0);
    i_btn = 5'b01111; cycle();
    i_btn = 5'b11111; cycle();
    chk("ovf_set", 32'(o_overflow), 1);
    i_rd = 1'b1; cycle(); i_rd = 1'b0;
    chk("head_after_pop", 32'(o_event), 32'h41);
    i_rd = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    i_rd = 1'b0;
    chk("btn4_entered", 32'(o_event), 32'h44);
    i_ovfl_clr = 1'b1; cycle(); i_ovfl_clr = 1'b0;
    chk("ovf_clr", 32'(o_overflow), 0);
    for (int c = 0; c < 5; c++) cycle();

    // Asynchronous reset mid-hold with a non-empty FIFO
    phase = "midrst";
    chk("fifo_nonempty", 32'(o_valid), 1);
    #2 i_reset_n = 1'b0;
    #1;
    model_reset();
    chk("valid0", 32'(o_valid), 0);
    chk("event0", 32'(o_event), 0);
    chk("ovf0", 32'(o_overflow), 0);
    chk("int0", 32'(o_int), 0);
    i_btn = 5'b00001;
    cycle();
    cycle();
    #3 i_reset_n = 1'b1;
    cycle();
    chk("not_yet", 32'(o_valid), 0);
    cycle();
    chk("held_press", 32'(o_event), 32'h40);

    // Random button activity, reads and overflow clears
    phase = "random";
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NB; i++) if ($urandom_range(0, 11) == 0) i_btn[i] = ~i_btn[i];
      i_rd       = (c < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 6) == 0);
      i_ovfl_clr = ($urandom_range(0, 19) == 0);
      cycle();
    end
    i_rd = 1'b0;
    i_ovfl_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
